// File: rtl/pkt_sanitizer.sv
// pkt_sanitizer: store-and-forward Avalon-ST packet checker.
// Buffers one packet, checks SOP/EOP framing and a length of 2..MAX_PKT_LEN,
// and forwards only well-formed packets. Each discarded packet pulses drop_o
// for one cycle; drop_cause_o tells why (0 runt, 1 overflow, 2 missing EOP,
// 3 orphan word) and holds its value until the next drop.
// Ports:
//   clk_i, arst_n_i                  clock, async active-low reset
//   snk_data_i/_startofpacket_i/_endofpacket_i/_valid_i, snk_ready_o   sink side
//   src_data_o/_startofpacket_o/_endofpacket_o/_valid_o, src_ready_i   source side
//   drop_o, drop_cause_o             discard pulse and its cause
module pkt_sanitizer #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              drop_o,
  output logic [1:0]        drop_cause_o
);

  localparam int CW = $clog2(MAX_PKT_LEN + 1);
  localparam int AW = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT_LEN);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {IDLE, RECV, DROP, SEND} state_t;

  state_t            state, state_n;
  logic [DWIDTH-1:0] mem [MAX_PKT_LEN];
  logic [CW-1:0]     cnt, cnt_n;     // words buffered so far
  logic [CW-1:0]     len, len_n;     // length of the packet being sent
  logic [CW-1:0]     rd, rd_n;       // index of the word on the source port
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic              load, finish, drop_n;
  logic [1:0]        cause_n;
  logic              snk_beat, src_beat;

  assign snk_beat = snk_valid_i & snk_ready_o;
  assign src_beat = src_valid_o & src_ready_i;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    rd_n    = rd;
    wr_en   = 1'b0;
    wr_addr = cnt[AW-1:0];
    load    = 1'b0;
    finish  = 1'b0;
    drop_n  = 1'b0;
    cause_n = drop_cause_o;
    case (state)
      // DROP only differs from IDLE for non-SOP words: they are swallowed
      // silently (the drop was already reported) until EOP.
      IDLE, DROP: if (snk_beat) begin
        if (snk_startofpacket_i && snk_endofpacket_i) begin
          drop_n  = 1'b1;
          cause_n = 2'd0;
          state_n = IDLE;
        end else if (snk_startofpacket_i) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          cnt_n   = ONE;
          state_n = RECV;
        end else if (state == IDLE) begin
          drop_n  = 1'b1;
          cause_n = 2'd3;
        end else if (snk_endofpacket_i) begin
          state_n = IDLE;
        end
      end
      RECV: if (snk_beat) begin
        if (snk_startofpacket_i) begin
          // New SOP abandons the partial packet; a SOP&EOP here reports
          // only the missing EOP, not an additional runt.
          drop_n  = 1'b1;
          cause_n = 2'd2;
          if (snk_endofpacket_i) begin
            state_n = IDLE;
          end else begin
            wr_en   = 1'b1;
            wr_addr = '0;
            cnt_n   = ONE;
          end
        end else if (cnt == MAX_CNT) begin
          drop_n  = 1'b1;
          cause_n = 2'd1;
          state_n = snk_endofpacket_i ? IDLE : DROP;
        end else begin
          wr_en = 1'b1;
          if (snk_endofpacket_i) begin
            len_n   = cnt + ONE;
            state_n = SEND;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
      end
      SEND: begin
        if (!src_valid_o) begin
          load = 1'b1;
          rd_n = '0;
        end else if (src_beat) begin
          if (src_endofpacket_o) begin
            finish  = 1'b1;
            state_n = IDLE;
          end else begin
            load = 1'b1;
            rd_n = rd + ONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state               <= IDLE;
      cnt                 <= '0;
      len                 <= '0;
      rd                  <= '0;
      snk_ready_o         <= 1'b0;
      src_data_o          <= '0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
      src_valid_o         <= 1'b0;
      drop_o              <= 1'b0;
      drop_cause_o        <= 2'd0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      len          <= len_n;
      rd           <= rd_n;
      snk_ready_o  <= (state_n != SEND);
      drop_o       <= drop_n;
      drop_cause_o <= cause_n;
      if (load) begin
        src_valid_o         <= 1'b1;
        src_data_o          <= mem[rd_n[AW-1:0]];
        src_startofpacket_o <= (rd_n == '0);
        src_endofpacket_o   <= (rd_n == len - ONE);
      end else if (finish) begin
        src_valid_o         <= 1'b0;
        src_data_o          <= '0;
        src_startofpacket_o <= 1'b0;
        src_endofpacket_o   <= 1'b0;
      end
    end
  end

  // Packet buffer: contents are only meaningful below cnt, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= snk_data_i;
  end

endmodule

// File: tb/tb_pkt_sanitizer.sv
// Bench for pkt_sanitizer: table of single-word drop cases, hand sequences
// for latency/overflow/abandon/reset corners, and randomized packets checked
// against a queue-based packet model.
module tb_pkt_sanitizer;
  localparam int MAXL = 16;

  logic       clk = 1'b0, arst_n = 1'b1;
  logic [7:0] snk_data = '0;
  logic       snk_sop = 1'b0, snk_eop = 1'b0, snk_valid = 1'b0, snk_ready;
  logic [7:0] src_data;
  logic       src_sop, src_eop, src_valid, src_ready = 1'b1, drop;
  logic [1:0] drop_cause;

  always #5 clk = ~clk;

  pkt_sanitizer #(.DWIDTH(8), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop), .snk_endofpacket_i(snk_eop),
    .snk_valid_i(snk_valid), .snk_ready_o(snk_ready),
    .src_data_o(src_data), .src_startofpacket_o(src_sop), .src_endofpacket_o(src_eop),
    .src_valid_o(src_valid), .src_ready_i(src_ready),
    .drop_o(drop), .drop_cause_o(drop_cause)
  );

  typedef struct packed {logic sop; logic eop; logic [7:0] data;} word_t;
  typedef struct {logic sop; logic eop; logic [7:0] data; logic [1:0] cause;} vec_t;

  int    errors = 0, checks = 0;
  word_t out_q[$], exp_out[$], cur[$];
  int    drop_q[$], exp_drop[$];
  int    mode = 0;      // model: 0 between packets, 1 collecting, 2 discarding
  int    rdy_mode = 0;  // src_ready: 0 always 1, 1 random, 2 always 0
  bit    rnd_vld = 1'b0;
  bit    prev_stall = 1'b0;
  word_t prev_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: one accepted sink word at a time, in packet terms.
  task automatic model_beat(input logic s, input logic e, input logic [7:0] d);
    if (s) begin
      if (mode == 1) exp_drop.push_back(2);
      cur.delete();
      if (e) begin
        if (mode != 1) exp_drop.push_back(0);
        mode = 0;
      end else begin
        cur.push_back({1'b1, 1'b0, d});
        mode = 1;
      end
    end else if (mode == 1) begin
      if (cur.size() == MAXL) begin
        exp_drop.push_back(1);
        cur.delete();
        mode = e ? 0 : 2;
      end else begin
        cur.push_back({1'b0, e, d});
        if (e) begin
          foreach (cur[i]) exp_out.push_back(cur[i]);
          cur.delete();
          mode = 0;
        end
      end
    end else if (mode == 2) begin
      if (e) mode = 0;
    end else begin
      exp_drop.push_back(3);
    end
  endtask

  // One cycle: observe outputs at the negedge, then drive the next inputs.
  task automatic tick(input logic v, input logic s, input logic e, input logic [7:0] d,
                      output bit acc);
    logic r;
    @(negedge clk);
    if (prev_stall) chk("stall_hold", {src_valid, src_sop, src_eop, src_data}, {1'b1, prev_word});
    if (src_valid) chk("snk_ready_low_in_send", snk_ready, 0);
    if (drop) drop_q.push_back(drop_cause);
    r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (src_valid && r) out_q.push_back({src_sop, src_eop, src_data});
    prev_stall = src_valid && !r;
    prev_word  = {src_sop, src_eop, src_data};
    acc = v && snk_ready;
    if (acc) model_beat(s, e, d);
    src_ready = r; snk_valid = v; snk_sop = s; snk_eop = e; snk_data = d;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) tick(1'b0, 1'b0, 1'b0, 8'($urandom), acc);
  endtask

  task automatic send_beat(input logic s, input logic e, input logic [7:0] d);
    bit acc = 1'b0;
    int n = 0;
    logic v;
    while (!acc) begin
      v = rnd_vld ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(v, s, e, d, acc);
      n++;
      if (n > 500) begin
        timeout_fail("sink_accept");
        return;
      end
    end
  endtask

  task automatic send_pkt(input int n, input logic [7:0] base, input bit sop_first, input bit eop_last);
    for (int i = 0; i < n; i++)
      send_beat(sop_first && i == 0, eop_last && i == n - 1, base + 8'(i));
  endtask

  task automatic drain_compare(input string name);
    int n = 0;
    int m;
    while ((out_q.size() < exp_out.size() || src_valid) && n < 3000) begin
      idle(1);
      n++;
    end
    if (n >= 3000) timeout_fail({name, "_drain"});
    idle(3);
    chk({name, "_out_count"}, out_q.size(), exp_out.size());
    m = (out_q.size() < exp_out.size()) ? out_q.size() : exp_out.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s_word%0d", name, i), out_q[i], exp_out[i]);
    chk({name, "_drop_count"}, drop_q.size(), exp_drop.size());
    m = (drop_q.size() < exp_drop.size()) ? drop_q.size() : exp_drop.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s_cause%0d", name, i), drop_q[i], exp_drop[i]);
    out_q.delete(); exp_out.delete(); drop_q.delete(); exp_drop.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_snk_ready"}, snk_ready, 0);
    chk({name, "_src_valid"}, src_valid, 0);
    chk({name, "_src_data"}, src_data, 0);
    chk({name, "_src_sopeop"}, {src_sop, src_eop}, 0);
    chk({name, "_drop"}, drop, 0);
    chk({name, "_cause"}, drop_cause, 0);
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{sop: 1'b1, eop: 1'b1, data: 8'hA1, cause: 2'd0};
    tbl[1] = '{sop: 1'b0, eop: 1'b0, data: 8'hA2, cause: 2'd3};
    tbl[2] = '{sop: 1'b0, eop: 1'b1, data: 8'hA3, cause: 2'd3};
    tbl[3] = '{sop: 1'b1, eop: 1'b1, data: 8'hA4, cause: 2'd0};

    // Reset values, held across edges, then ready rises on first edge after release
    #1 arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk_all_zero("reset");
    @(negedge clk);
    #2 arst_n = 1'b1;
    chk("ready_before_edge", snk_ready, 0);
    @(posedge clk);
    #1 chk("ready_after_release", snk_ready, 1);

    // 2-word packet, back-to-back, first output one cycle after EOP beat
    send_beat(1'b1, 1'b0, 8'h11);
    send_beat(1'b0, 1'b1, 8'h22);
    idle(1);
    chk("lat_not_yet_valid", src_valid, 0);
    chk("lat_ready_low", snk_ready, 0);
    idle(1);
    chk("lat_first_valid", {src_valid, src_sop, src_eop, src_data}, {1'b1, 1'b1, 1'b0, 8'h11});
    drain_compare("t1");

    // 16-word packet with sparse valid and random ready
    rnd_vld = 1'b1; rdy_mode = 1;
    send_pkt(16, 8'h40, 1'b1, 1'b1);
    drain_compare("t2");

    // 17-word overflow, then a clean 3-word packet
    send_pkt(17, 8'h60, 1'b1, 1'b1);
    send_pkt(3, 8'h80, 1'b1, 1'b1);
    drain_compare("t3");

    // Single-word drop cases from the table
    rnd_vld = 1'b0; rdy_mode = 0;
    for (int i = 0; i < 4; i++) begin
      send_beat(tbl[i].sop, tbl[i].eop, tbl[i].data);
      idle(1);
      chk($sformatf("tbl%0d_drop", i), drop, 1);
      chk($sformatf("tbl%0d_cause", i), drop_cause, tbl[i].cause);
      chk($sformatf("tbl%0d_no_out", i), src_valid, 0);
      idle(1);
      chk($sformatf("tbl%0d_pulse_end", i), drop, 0);
      chk($sformatf("tbl%0d_cause_hold", i), drop_cause, tbl[i].cause);
    end
    drain_compare("t4");

    // Abandoned 2-word partial, then a 4-word packet
    rnd_vld = 1'b1; rdy_mode = 1;
    send_pkt(2, 8'h90, 1'b1, 1'b0);
    send_pkt(4, 8'hA0, 1'b1, 1'b1);
    drain_compare("t5");

    // Async reset mid-SEND, then a 5-word packet
    rdy_mode = 2;
    send_pkt(4, 8'hB0, 1'b1, 1'b1);
    idle(4);
    chk("t6_in_send", src_valid, 1);
    #2 arst_n = 1'b0;
    #1 chk_all_zero("t6_reset");
    #1 arst_n = 1'b1;
    out_q.delete(); exp_out.delete(); drop_q.delete(); exp_drop.delete(); cur.delete();
    mode = 0; prev_stall = 1'b0;
    rdy_mode = 1;
    send_pkt(5, 8'hC0, 1'b1, 1'b1);
    drain_compare("t6");

    // Randomized packets, some malformed
    for (int p = 0; p < 60; p++) begin
      send_pkt($urandom_range(1, 19), 8'($urandom), ($urandom % 6) != 0, ($urandom % 6) != 0);
      if (($urandom % 4) == 0) idle($urandom_range(1, 4));
    end
    send_pkt(3, 8'hE0, 1'b1, 1'b1);  // closes any packet left open
    drain_compare("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
